fwd_scoreboard: RTL
===================

// Module: fwd_scoreboard
// PURPOSE
//  Next-generation bypass control for the ISSUE_WIDTH-wide in-order pipeline. Tracks in-flight
//  register producers across FWD_DEPTH post-EX stages and selects the forwarding source for each
//  EX-stage consumer. Raises stall while the youngest matching producer's result is not yet
//  forwardable (load-use, multi-cycle ops). Sits beside the ID/EX register, ahead of the EX operand muxes.
// PARAMETERS
//  ISSUE_WIDTH   2    slots per bundle; slot 0 is oldest in program order
//  FWD_DEPTH     2    bypassable stages after EX (1 = EX/MEM, 2 = MEM/WB, ...)
//  REG_IDX_W     5    architectural register index width
//  CNT_W         32   stall performance counter width
//  STG_W         $clog2(FWD_DEPTH+1)   derived; stage select width (0 = register file)
// PORTS
//  clock          in   1                    pipeline clock
//  reset_n        in   1                    asynchronous, active-low reset
//  ex_valid       in   [W]                  EX-stage slot holds a live instruction
//  ex_rs1/ex_rs2  in   [W][REG_IDX_W]       consumer source indices
//  ex_use_rs1/2   in   [W]                  source actually read
//  ex_regwrite    in   [W]                  slot writes a register (already excludes halt/illegal/store)
//  ex_dest        in   [W][REG_IDX_W]       producer destination index
//  ex_rdy_stg     in   [W][STG_W]           first stage (1..FWD_DEPTH) where the result is forwardable
//  flush          in   1                    kill the EX bundle this cycle
//  fwdA_stage     out  [W][STG_W]           rs1 source stage; 0 = register file
//  fwdA_slot      out  [W][$clog2(W)]       slot within the selected stage
//  fwdB_stage     out  [W][STG_W]           rs2 equivalent
//  fwdB_slot      out  [W][$clog2(W)]       rs2 equivalent
//  stall          out  1                    hold IF..EX this cycle; block inserts a bubble
//  stall_cnt      out  [CNT_W]              saturating count of stalled cycles
// BEHAVIOUR
//  - Internal state: trk[1..FWD_DEPTH][W] = {valid, dest, rdy_stg}. Each clock, trk[k] <= trk[k-1].
//    trk[1] <= EX bundle (valid = ex_valid & ex_regwrite & dest!=0) unless stall|flush, else all-invalid bubble.
//    Entries shifting past FWD_DEPTH are dropped; the register file holds their value by then.
//  - Match for each consumer source (use=1, idx!=0, ex_valid=1): scan trk stages 1..FWD_DEPTH.
//    The lowest stage wins; within a stage the highest slot wins. The first match ends the search;
//    there is no fallback to an older producer.
//  - Ready: a match in stage k with k >= rdy_stg selects {stage=k, slot}. With k < rdy_stg the source
//    is not ready -> stall=1 and selects are don't-care.
//  - No match, x0, or use=0 -> stage=0, slot=0.
//  - Selects and stall are combinational from trk + EX inputs in the same cycle (0-cycle latency).
//    trk updates on clock posedge.
//  - flush=1 forces stall=0 that cycle and inserts a bubble. Older trk entries keep shifting.
//  - Intra-bundle RAW (slot i reads slot j<i dest) is excluded by decode. Bench assertion only;
//    no forwarding is done for it.
//  - ex_rdy_stg must be 1..FWD_DEPTH for a valid regwrite slot (assertion); 0 is treated as 1.
//  - stall_cnt increments each cycle stall=1 and saturates at all-ones.
//  - Reset (async, reset_n=0): all trk entries invalid, stall_cnt=0. Outputs then read stall=0 and all
//    fwd*=0 whenever EX inputs are invalid. Reset mid-stall drops pending producers immediately.
// STRUCTURE
//  - Shared package (sys_defs): FWD_STAGE_RF=0 constant, trk_entry_t {valid, dest, rdy_stg}, and
//    fwd_sel_t {stage, slot} typedefs used by the EX operand muxes.
//  - One sub-module, fwd_src_select: per-source priority search over trk returning {hit, ready, sel}.
//    It is instantiated 2*ISSUE_WIDTH times. The top module holds the trk shift pipeline, stall OR-reduce
//    and the counter.
// TESTING (ISSUE_WIDTH=2, FWD_DEPTH=3 unless noted)
//  1. ALU chain: cyc0 slot0 dest=x5 rdy=1; cyc1 slot1 rs1=x5
//     -> fwdA_stage[1]=1, fwdA_slot[1]=0, stall=0.
//  2. Load-use: cyc0 slot1 dest=x7 rdy=2; cyc1 slot0 rs2=x7 -> stall=1 for one cycle;
//     cyc2 -> fwdB_stage[0]=2, fwdB_slot[0]=1, stall=0, stall_cnt=1.
//  3. Priority: x3 written by stage2 slot1 and stage1 slot0 -> stage1/slot0.
//     x3 written by stage1 slots 0 and 1 -> stage1/slot1.
//  4. Mul rdy=3 followed by a consumer -> exactly 2 stall cycles, then stage=3.
//     Same with flush asserted in the 2nd stall cycle -> stall=0 that cycle and the producer still
//     retires from trk on schedule.
//  5. Filters: dest=x0, regwrite=0, use_rs=0, or ex_valid=0 -> never forwards or stalls.
//     A producer 4 cycles old -> stage=0 (register file).
//  6. reset_n pulsed low mid-stall (not clock-aligned) -> stall=0 and stall_cnt=0 immediately;
//     trk empty on the first post-reset clock.

Source files
------------

// File: rtl/sys_defs.sv
// Shared pipeline definitions for the bypass network: tracker entry and forward-select types.
// The struct field widths set the supported envelope: register index 5 bits, up to 3 bypass
// stages after EX and up to 2 issue slots.
package sys_defs;

  // Stage select value meaning "read the register file, no bypass".
  localparam int FWD_STAGE_RF = 0;

  localparam int TRK_IDX_W  = 5;
  localparam int TRK_STG_W  = 2;
  localparam int TRK_SLOT_W = 1;

  // One in-flight producer as seen by the bypass logic.
  typedef struct packed {
    logic                  valid;
    logic [TRK_IDX_W-1:0]  dest;
    logic [TRK_STG_W-1:0]  rdy_stg;
  } trk_entry_t;

  // Operand mux select handed to the EX stage.
  typedef struct packed {
    logic [TRK_STG_W-1:0]  stage;
    logic [TRK_SLOT_W-1:0] slot;
  } fwd_sel_t;

  // A ready stage of 0 is meaningless for a producer, so it is read as "ready right after EX".
  function automatic logic [TRK_STG_W-1:0] eff_rdy_stg(input logic [TRK_STG_W-1:0] rdy);
    return (rdy == '0) ? TRK_STG_W'(1) : rdy;
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Priority search for one consumer source over the in-flight producer tracker.
// Youngest producer wins: lowest stage first, then highest slot within that stage.
module fwd_src_select
  import sys_defs::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int FWD_DEPTH   = 2
) (
  input  logic                                          use_i,
  input  logic [TRK_IDX_W-1:0]                          idx_i,
  input  trk_entry_t [FWD_DEPTH-1:0][ISSUE_WIDTH-1:0]   trk_i,
  output logic                                          hit_o,
  output logic                                          ready_o,
  output fwd_sel_t                                      sel_o
);

  // First match ends the search; an older producer of the same register is never used as fallback.
  always_comb begin
    hit_o       = 1'b0;
    ready_o     = 1'b0;
    sel_o.stage = TRK_STG_W'(FWD_STAGE_RF);
    sel_o.slot  = '0;
    if (use_i && (idx_i != '0)) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        for (int s = ISSUE_WIDTH - 1; s >= 0; s--) begin
          if (!hit_o && trk_i[k][s].valid && (trk_i[k][s].dest == idx_i)) begin
            hit_o = 1'b1;
            if (TRK_STG_W'(k + 1) >= eff_rdy_stg(trk_i[k][s].rdy_stg)) begin
              ready_o     = 1'b1;
              sel_o.stage = TRK_STG_W'(k + 1);
              sel_o.slot  = TRK_SLOT_W'(s);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Bypass scoreboard for the in-order issue pipeline: tracks producers in the post-EX stages,
// selects the forwarding source for every EX operand and stalls on not-yet-forwardable results.
module fwd_scoreboard
  import sys_defs::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int FWD_DEPTH   = 2,
  parameter int REG_IDX_W   = 5,
  parameter int CNT_W       = 32,
  localparam int STG_W      = $clog2(FWD_DEPTH + 1),
  localparam int SLOT_W     = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [ISSUE_WIDTH-1:0]                  ex_valid,
  input  logic [ISSUE_WIDTH-1:0][REG_IDX_W-1:0]   ex_rs1,
  input  logic [ISSUE_WIDTH-1:0][REG_IDX_W-1:0]   ex_rs2,
  input  logic [ISSUE_WIDTH-1:0]                  ex_use_rs1,
  input  logic [ISSUE_WIDTH-1:0]                  ex_use_rs2,
  input  logic [ISSUE_WIDTH-1:0]                  ex_regwrite,
  input  logic [ISSUE_WIDTH-1:0][REG_IDX_W-1:0]   ex_dest,
  input  logic [ISSUE_WIDTH-1:0][STG_W-1:0]       ex_rdy_stg,
  input  logic                                    flush,
  output logic [ISSUE_WIDTH-1:0][STG_W-1:0]       fwdA_stage,
  output logic [ISSUE_WIDTH-1:0][SLOT_W-1:0]      fwdA_slot,
  output logic [ISSUE_WIDTH-1:0][STG_W-1:0]       fwdB_stage,
  output logic [ISSUE_WIDTH-1:0][SLOT_W-1:0]      fwdB_slot,
  output logic                                    stall,
  output logic [CNT_W-1:0]                        stall_cnt
);

  trk_entry_t [FWD_DEPTH-1:0][ISSUE_WIDTH-1:0] trk_q, trk_d;
  trk_entry_t [ISSUE_WIDTH-1:0]                ex_entry;
  fwd_sel_t   [ISSUE_WIDTH-1:0]                sel_a, sel_b;
  logic       [ISSUE_WIDTH-1:0]                hit_a, rdy_a, hit_b, rdy_b;
  logic                                        stall_raw;
  logic       [CNT_W-1:0]                      cnt_q, cnt_d;

  // Producer view of the EX bundle; x0 and non-writing slots never become trackable.
  always_comb begin
    ex_entry = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ex_entry[i].valid   = ex_valid[i] & ex_regwrite[i] & (ex_dest[i] != '0);
      ex_entry[i].dest    = TRK_IDX_W'(ex_dest[i]);
      ex_entry[i].rdy_stg = TRK_STG_W'(ex_rdy_stg[i]);
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
    fwd_src_select #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .FWD_DEPTH   (FWD_DEPTH)
    ) u_src_a (
      .use_i   (ex_valid[i] & ex_use_rs1[i]),
      .idx_i   (TRK_IDX_W'(ex_rs1[i])),
      .trk_i   (trk_q),
      .hit_o   (hit_a[i]),
      .ready_o (rdy_a[i]),
      .sel_o   (sel_a[i])
    );

    fwd_src_select #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .FWD_DEPTH   (FWD_DEPTH)
    ) u_src_b (
      .use_i   (ex_valid[i] & ex_use_rs2[i]),
      .idx_i   (TRK_IDX_W'(ex_rs2[i])),
      .trk_i   (trk_q),
      .hit_o   (hit_b[i]),
      .ready_o (rdy_b[i]),
      .sel_o   (sel_b[i])
    );

    assign fwdA_stage[i] = STG_W'(sel_a[i].stage);
    assign fwdA_slot[i]  = SLOT_W'(sel_a[i].slot);
    assign fwdB_stage[i] = STG_W'(sel_b[i].stage);
    assign fwdB_slot[i]  = SLOT_W'(sel_b[i].slot);
  end

  // Any source waiting on a producer that is still in flight holds the front end; a flush overrides.
  always_comb begin
    stall_raw = |((hit_a & ~rdy_a) | (hit_b & ~rdy_b));
    stall     = stall_raw & ~flush;
  end

  // Tracker shift: stalled or flushed bundles enter as a bubble, older entries always advance.
  always_comb begin
    trk_d    = '0;
    trk_d[0] = (stall | flush) ? '0 : ex_entry;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset empties the tracker so pending stalls drop immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trk_q <= '0;
      cnt_q <= '0;
    end else begin
      trk_q <= trk_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
